// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end: reset PC, the bubble
// instruction word, the fetch-controller states and the IF/ID tuple.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic [31:0] instr;
    logic        adel;
  } ifid_t;

  // Value the IF/ID register takes out of reset: an empty slot at RESET_PC.
  function automatic ifid_t ifid_reset_value();
    ifid_t v;
    v.valid = 1'b0;
    v.pc    = RESET_PC;
    v.pc_4  = RESET_PC + 32'd4;
    v.instr = NOP;
    v.adel  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. A bubble empties the slot but keeps the PC fields
// so later stages still see a sensible address; a load takes a full tuple;
// otherwise the register holds.
module ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // Bubble wins over load so a redirect can never let a stale word through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= ifid_reset_value();
    end else if (bubble) begin
      q.valid <= 1'b0;
      q.instr <= NOP;
      q.adel  <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch controller. Runs the req/ack handshake with instruction
// memory, keeps the PC frozen while a fetch is outstanding, parks a returned
// word in a one-entry buffer when ID stalls, and drains an in-flight request
// whose result was made stale by a redirect.
module if_fetch
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic [31:0] pc_4,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_4,
  output logic [31:0] ifid_instr,
  output logic        ifid_adel
);

  fetch_state_t state;
  fetch_state_t next_state;

  ifid_t       hold_buf;
  ifid_t       fetched;
  ifid_t       ifid_d;
  ifid_t       ifid_q;
  logic [31:0] drain_addr;

  logic misaligned;
  logic got;
  logic ifid_load;
  logic ifid_bubble;
  logic buf_load;
  logic buf_clear;
  logic drain_load;

  // A misaligned PC never reaches memory; it completes at once as a NOP
  // carrying the address-error flag.
  assign misaligned = (pc[1:0] != 2'b00);
  assign got        = imem_ack || misaligned;

  assign fetched.valid = 1'b1;
  assign fetched.pc    = pc;
  assign fetched.pc_4  = pc_4;
  assign fetched.instr = misaligned ? NOP : imem_rdata;
  assign fetched.adel  = misaligned;

  assign ifid_d = (state == S_HOLD) ? hold_buf : fetched;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, handshake outputs and IF/ID/buffer controls; flush beats stall.
  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    drain_load  = 1'b0;
    case (state)
      S_IDLE: begin
        next_state = S_REQ;
        if (flush || !stall) begin
          ifid_bubble = 1'b1;
        end
      end
      S_REQ: begin
        imem_req = !misaligned;
        if (flush) begin
          pc_en       = 1'b1;
          ifid_bubble = 1'b1;
          if (!got) begin
            drain_load = 1'b1;
            next_state = S_DRAIN;
          end
        end else if (got) begin
          pc_en = 1'b1;
          if (!stall) begin
            ifid_load = 1'b1;
          end else begin
            buf_load   = 1'b1;
            next_state = S_HOLD;
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_en       = 1'b1;
          ifid_bubble = 1'b1;
          buf_clear   = 1'b1;
          next_state  = S_REQ;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          buf_clear  = 1'b1;
          next_state = S_REQ;
        end
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        pc_en     = flush;
        if (flush || !stall) begin
          ifid_bubble = 1'b1;
        end
        if (imem_ack) begin
          next_state = S_REQ;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // One-entry hold buffer for a word that returned while ID was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_buf <= '0;
    end else if (buf_clear) begin
      hold_buf <= '0;
    end else if (buf_load) begin
      hold_buf <= fetched;
    end
  end

  // Address of the abandoned request, held stable until memory acks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_addr <= 32'd0;
    end else if (drain_load) begin
      drain_addr <= pc;
    end
  end

  ifid_reg u_ifid_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign ifid_valid = ifid_q.valid;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_pc_4  = ifid_q.pc_4;
  assign ifid_instr = ifid_q.instr;
  assign ifid_adel  = ifid_q.adel;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a PC register and instruction memory around the DUT,
// a transaction-level model of the fetch stage compared every cycle, and
// directed sequences with literal expectations at the interesting points.
module tb_if_fetch;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_4;
  logic [31:0] ifid_instr;
  logic        ifid_adel;
  logic [31:0] target;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  if_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .pc_4       (pc_4),
    .pc_en      (pc_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_pc_4  (ifid_pc_4),
    .ifid_instr (ifid_instr),
    .ifid_adel  (ifid_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word encodes its own address so a wrong fetch shows.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h2008_0001 + (a - 32'h0040_0000);
  endfunction

  assign imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;
  assign pc_4       = pc + 32'd4;

  // What the stage is doing, in transaction terms.
  typedef struct packed {
    logic        started;
    logic        parked;
    logic [31:0] p_pc;
    logic [31:0] p_pc4;
    logic [31:0] p_instr;
    logic        p_adel;
    logic        draining;
    logic [31:0] d_addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        adel;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r       = '0;
    r.pc    = 32'h0040_0000;
    r.pc4   = 32'h0040_0004;
    r.instr = 32'h0000_0000;
    return r;
  endfunction

  function automatic model_t emptied(input model_t s);
    model_t r;
    r       = s;
    r.valid = 1'b0;
    r.instr = 32'h0000_0000;
    r.adel  = 1'b0;
    return r;
  endfunction

  // One clock of the fetch stage as seen from outside.
  function automatic model_t model_next(input model_t s);
    model_t      n;
    logic        bad;
    logic        done;
    logic [31:0] word;
    n    = s;
    bad  = (pc % 4) != 0;
    done = imem_ack || bad;
    word = bad ? 32'h0000_0000 : memf(pc);
    if (!s.started) begin
      n.started = 1'b1;
      if (flush || !stall) n = emptied(n);
    end else if (s.draining) begin
      if (flush || !stall) n = emptied(n);
      if (imem_ack) n.draining = 1'b0;
    end else if (s.parked) begin
      if (flush) begin
        n        = emptied(n);
        n.parked = 1'b0;
      end else if (!stall) begin
        n.valid  = 1'b1;
        n.pc     = s.p_pc;
        n.pc4    = s.p_pc4;
        n.instr  = s.p_instr;
        n.adel   = s.p_adel;
        n.parked = 1'b0;
      end
    end else begin
      if (flush) begin
        n = emptied(n);
        if (!done) begin
          n.draining = 1'b1;
          n.d_addr   = pc;
        end
      end else if (done) begin
        if (!stall) begin
          n.valid = 1'b1;
          n.pc    = pc;
          n.pc4   = pc + 32'd4;
          n.instr = word;
          n.adel  = bad;
        end else begin
          n.parked  = 1'b1;
          n.p_pc    = pc;
          n.p_pc4   = pc + 32'd4;
          n.p_instr = word;
          n.p_adel  = bad;
        end
      end else if (!stall) begin
        n = emptied(n);
      end
    end
    return n;
  endfunction

  // Advance the model alongside the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m);
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  task automatic checkOutput();
    logic        req_x;
    logic        en_x;
    logic        addr_chk;
    logic [31:0] addr_x;
    req_x    = 1'b0;
    en_x     = 1'b0;
    addr_chk = 1'b0;
    addr_x   = pc;
    if (rst_n && m.started) begin
      if (m.draining) begin
        req_x    = 1'b1;
        addr_x   = m.d_addr;
        addr_chk = 1'b1;
        en_x     = flush;
      end else if (m.parked) begin
        en_x = flush;
      end else begin
        req_x    = (pc % 4) == 0;
        addr_chk = 1'b1;
        en_x     = flush || imem_ack || ((pc % 4) != 0);
      end
    end
    checkValue("imem_req", {31'd0, imem_req}, {31'd0, req_x});
    checkValue("pc_en", {31'd0, pc_en}, {31'd0, en_x});
    if (addr_chk) checkValue("imem_addr", imem_addr, addr_x);
    checkValue("ifid_valid", {31'd0, ifid_valid}, {31'd0, m.valid});
    checkValue("ifid_pc", ifid_pc, m.pc);
    checkValue("ifid_pc_4", ifid_pc_4, m.pc4);
    checkValue("ifid_instr", ifid_instr, m.instr);
    checkValue("ifid_adel", {31'd0, ifid_adel}, {31'd0, m.adel});
  endtask

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) checkOutput();
  end

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic applyStimulus(input logic st, input logic fl, input logic ak, input logic [31:0] tgt);
    stall    = st;
    flush    = fl;
    imem_ack = ak;
    target   = tgt;
    #1;
  endtask

  // Finish the cycle and update the PC register from the DUT's pc_en.
  task automatic stepCycle();
    logic en_s;
    logic fl_s;
    @(negedge clk);
    #1;
    en_s = pc_en;
    fl_s = flush;
    @(posedge clk);
    #2;
    if (en_s) pc = fl_s ? target : pc_4;
  endtask

  task automatic run(input logic st, input logic fl, input logic ak, input logic [31:0] tgt);
    applyStimulus(st, fl, ak, tgt);
    stepCycle();
  endtask

  initial begin
    rst_n    = 1'b1;
    pc       = 32'h0040_0000;
    stall    = 1'b0;
    flush    = 1'b0;
    imem_ack = 1'b0;
    target   = 32'd0;
    #1;
    rst_n  = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkValue("rst_ifid_pc", ifid_pc, 32'h0040_0000);
    checkValue("rst_ifid_pc_4", ifid_pc_4, 32'h0040_0004);
    checkValue("rst_imem_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] reset release and zero-wait fetch");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("idle_req", {31'd0, imem_req}, 32'd0);
    checkValue("idle_pc_en", {31'd0, pc_en}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("first_addr", imem_addr, 32'h0040_0000);
    checkValue("first_req", {31'd0, imem_req}, 32'd1);
    stepCycle();
    checkValue("first_valid", {31'd0, ifid_valid}, 32'd1);
    checkValue("first_pc", ifid_pc, 32'h0040_0000);
    checkValue("first_instr", ifid_instr, 32'h2008_0001);

    $display("[TB] two wait cycles at 0x00400004");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkValue("wait_addr", imem_addr, 32'h0040_0004);
    checkValue("wait_pc_en", {31'd0, pc_en}, 32'd0);
    stepCycle();
    checkValue("wait_bubble", {31'd0, ifid_valid}, 32'd0);
    run(1'b0, 1'b0, 1'b0, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("late_pc", ifid_pc, 32'h0040_0004);
    checkValue("late_pc_4", ifid_pc_4, 32'h0040_0008);
    checkValue("late_instr", ifid_instr, 32'h2008_0005);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    run(1'b1, 1'b0, 1'b0, 32'd0);
    checkValue("stall_noack_hold", ifid_pc, 32'h0040_000C);

    $display("[TB] stall on the ack cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
    checkValue("stall_ack_pc_en", {31'd0, pc_en}, 32'd1);
    stepCycle();
    checkValue("stall_hold_pc", ifid_pc, 32'h0040_000C);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd0);
    checkValue("hold_req", {31'd0, imem_req}, 32'd0);
    checkValue("hold_pc_en", {31'd0, pc_en}, 32'd0);
    stepCycle();
    run(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("unstall_pc_en", {31'd0, pc_en}, 32'd0);
    stepCycle();
    checkValue("unstall_pc", ifid_pc, 32'h0040_0010);
    checkValue("unstall_instr", ifid_instr, 32'h2008_0011);
    run(1'b0, 1'b0, 1'b1, 32'd0);

    $display("[TB] flush with request in flight");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0100);
    checkValue("flush_pc_en", {31'd0, pc_en}, 32'd1);
    stepCycle();
    checkValue("flush_bubble", {31'd0, ifid_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkValue("drain_addr", imem_addr, 32'h0040_0018);
    checkValue("drain_req", {31'd0, imem_req}, 32'd1);
    stepCycle();
    run(1'b0, 1'b0, 1'b0, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("drain_discard", {31'd0, ifid_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("redirect_addr", imem_addr, 32'h0040_0100);
    stepCycle();
    checkValue("redirect_pc", ifid_pc, 32'h0040_0100);
    checkValue("redirect_instr", ifid_instr, 32'h2008_0101);

    $display("[TB] flush together with stall");
    run(1'b1, 1'b1, 1'b1, 32'h0040_0200);
    checkValue("fs_req_bubble", {31'd0, ifid_valid}, 32'd0);
    run(1'b1, 1'b0, 1'b1, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0040_0300);
    checkValue("fs_hold_pc_en", {31'd0, pc_en}, 32'd1);
    stepCycle();
    checkValue("fs_hold_bubble", {31'd0, ifid_valid}, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("fs_hold_dropped", ifid_pc, 32'h0040_0300);
    checkValue("fs_hold_instr", ifid_instr, 32'h2008_0301);

    $display("[TB] second redirect while draining");
    run(1'b0, 1'b1, 1'b0, 32'h0040_0400);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0040_0500);
    checkValue("redrain_pc_en", {31'd0, pc_en}, 32'd1);
    checkValue("redrain_addr", imem_addr, 32'h0040_0304);
    stepCycle();
    run(1'b1, 1'b0, 1'b1, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("redrain_pc", ifid_pc, 32'h0040_0500);

    $display("[TB] misaligned PC");
    pc = 32'h0040_0002;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    checkValue("adel_req", {31'd0, imem_req}, 32'd0);
    checkValue("adel_pc_en", {31'd0, pc_en}, 32'd1);
    stepCycle();
    checkValue("adel_valid", {31'd0, ifid_valid}, 32'd1);
    checkValue("adel_flag", {31'd0, ifid_adel}, 32'd1);
    checkValue("adel_instr", ifid_instr, 32'h0000_0000);
    checkValue("adel_pc", ifid_pc, 32'h0040_0002);
    run(1'b1, 1'b0, 1'b0, 32'd0);
    pc = 32'h0040_0600;
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("adel_buf_pc", ifid_pc, 32'h0040_0006);
    checkValue("adel_buf_flag", {31'd0, ifid_adel}, 32'd1);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("aligned_again", {31'd0, ifid_adel}, 32'd0);
    checkValue("aligned_instr", ifid_instr, 32'h2008_0601);

    $display("[TB] reset during an outstanding request");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    checkValue("midrst_req", {31'd0, imem_req}, 32'd0);
    checkValue("midrst_pc_en", {31'd0, pc_en}, 32'd0);
    checkValue("midrst_valid", {31'd0, ifid_valid}, 32'd0);
    checkValue("midrst_pc", ifid_pc, 32'h0040_0000);
    stepCycle();
    pc    = 32'h0040_0000;
    rst_n = 1'b1;
    run(1'b0, 1'b0, 1'b1, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    run(1'b0, 1'b0, 1'b1, 32'd0);
    checkValue("post_rst_pc", ifid_pc, 32'h0040_0004);

    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
